// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock, MSB first.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              begin a division (sampled only in IDLE)
//   dividend, divisor  unsigned N-bit operands, captured on the accepting edge
//   quotient           result of the last completed operation
//   remainder          result of the last completed operation
//   busy               high while in RUN or DONE
//   done               one-cycle completion pulse (DONE state)
//   div_by_zero        last completed operation had divisor == 0
//
// A nonzero divisor takes N RUN cycles plus one DONE cycle.
// A zero divisor goes straight to DONE with quotient = all ones and
// remainder = dividend.
module div_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  dvd;    // shifts out dividend bits at the top, takes quotient bits in at the bottom
  logic [N-1:0]  dvs;
  logic [N:0]    prem;   // partial remainder, one bit wider so 2^N-1 / 2^N-1 cannot overflow
  logic [CW-1:0] cnt;
  logic [N:0]    trial;
  logic [N:0]    diff;
  logic [N:0]    step_rem;
  logic          qbit;
  logic          last;

  // One restoring step
  always_comb begin
    trial    = (prem << 1) | (N+1)'(dvd[N-1]);
    diff     = trial - {1'b0, dvs};
    qbit     = (trial >= {1'b0, dvs});
    step_rem = qbit ? diff : trial;
    last     = (cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            dvd  <= dividend;
            dvs  <= divisor;
            prem <= '0;
            cnt  <= CW'(N);
          end
        end
        RUN: begin
          dvd  <= {dvd[N-2:0], qbit};
          prem <= step_rem;
          cnt  <= cnt - CW'(1);
          // Results are published only on the final step, so outputs never show partial values
          if (last) begin
            quotient    <= {dvd[N-2:0], qbit};
            remainder   <= step_rem[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq (N=4).
module tb_div_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend, divisor;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int n_run  = 0;
  int n_fail = 0;
  logic prev_done = 1'b0;

  div_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // done must never be high two samples in a row
  always @(negedge clk) begin
    if (rst_n && prev_done) chk("done_width", 32'(done), 0);
    prev_done = done && rst_n;
  end

  // Issue one op, wait for done, check latency, busy count, results, hold during RUN.
  task automatic do_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int eq, input int er, input int edbz, input int elat);
    int lat, nbusy;
    logic [N-1:0] q0, r0;
    logic d0, stable;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    q0 = quotient; r0 = remainder; d0 = div_by_zero;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; nbusy = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (!done && (quotient !== q0 || remainder !== r0 || div_by_zero !== d0)) stable = 1'b0;
    end while (!done && lat < 20);
    chk({tag, "_lat"},    32'(lat), 32'(elat));
    chk({tag, "_busy"},   32'(nbusy), 32'(elat));
    chk({tag, "_q"},      32'(quotient), 32'(eq));
    chk({tag, "_r"},      32'(remainder), 32'(er));
    chk({tag, "_dbz"},    32'(div_by_zero), 32'(edbz));
    chk({tag, "_stable"}, 32'(stable), 1);
  endtask

  initial begin
    int lat, seen;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_q",    32'(quotient), 0);
    chk("rst_r",    32'(remainder), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dbz",  32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after release is accepted
    do_div("d13_3", 4'd13, 4'd3, 4, 1, 0, 5);
    do_div("d15_1", 4'd15, 4'd1, 15, 0, 0, 5);
    do_div("d2_9",  4'd2,  4'd9, 0, 2, 0, 5);
    do_div("d15_15", 4'd15, 4'd15, 1, 0, 0, 5);
    do_div("d0_5",  4'd0,  4'd5, 0, 0, 0, 5);
    do_div("d7_0",  4'd7,  4'd0, 15, 7, 1, 1);
    do_div("d6_3",  4'd6,  4'd3, 2, 0, 0, 5);

    // full operand sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (b == 0) do_div($sformatf("sw%0d_%0d", a, b), 4'(a), 4'(b), 15, a, 1, 1);
        else        do_div($sformatf("sw%0d_%0d", a, b), 4'(a), 4'(b), a / b, a % b, 0, 5);

    // start held high, operands changed mid-RUN
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin dividend = 4'd2; divisor = 4'd7; end
    end while (!done && lat < 20);
    chk("hold_lat", 32'(lat), 5);
    chk("hold_q",   32'(quotient), 4);
    chk("hold_r",   32'(remainder), 1);
    @(negedge clk);
    chk("hold_idle", 32'(busy), 0);
    @(negedge clk);
    chk("hold_restart", 32'(busy), 1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("hold2_lat", 32'(lat), 5);
    chk("hold2_q",   32'(quotient), 0);
    chk("hold2_r",   32'(remainder), 2);

    // reset pulse mid-RUN: leave nonzero results first
    do_div("pre_rst", 4'd7, 4'd0, 15, 7, 1, 1);
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_q",    32'(quotient), 0);
    chk("arst_r",    32'(remainder), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_dbz",  32'(div_by_zero), 0);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (done || busy) seen++; end
    chk("arst_nodone", 32'(seen), 0);
    do_div("d9_2", 4'd9, 4'd2, 4, 1, 0, 5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter N, default 4, SHALL set the operand width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock; all state SHALL update on this edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  N  unsigned dividend, sampled on the accepting edge.
REQ-006 divisor  input  N  unsigned divisor, sampled on the accepting edge.
REQ-007 quotient  output  N  unsigned quotient of the last completed operation.
REQ-008 remainder  output  N  unsigned remainder of the last completed operation.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 div_by_zero  output  1  high when the last completed operation had divisor 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 and divisor!=0: on the edge, latch the operands, clear the partial remainder, load the step counter with N, and go to RUN.
REQ-014 IDLE with start=1 and divisor=0: on the edge, go directly to DONE with quotient = all ones, remainder = dividend, and div_by_zero = 1.
REQ-015 RUN: each edge SHALL perform one restoring step, MSB first.
REQ-016 Restoring step: shift {partial remainder, next dividend bit} left by one into an N+1-bit trial value; trial >= divisor -> subtract the divisor and set the quotient bit to 1, else keep the trial value and set the quotient bit to 0.
REQ-017 After the N-th RUN edge, quotient and remainder SHALL update to the final values, div_by_zero SHALL clear, and the FSM SHALL go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-019 Latency: with divisor!=0, done is high in the cycle after edge N+1, counting the accepting edge as edge 1. With divisor=0, done is high in the cycle after the accepting edge.
REQ-020 start in RUN or DONE SHALL be ignored, including in the DONE cycle; a new start is accepted only in IDLE.
REQ-021 Operand input changes after the accepting edge SHALL NOT affect the result.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from completion until the next completion; they SHALL NOT show intermediate values during RUN.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0, including dividend < divisor (quotient 0, remainder = dividend).
REQ-024 The partial remainder datapath SHALL be N+1 bits wide so that no step overflows at dividend = divisor = 2^N-1.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, and clear the counter and internal registers, regardless of clock.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse.
REQ-027 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (N=4)
REQ-028 start with 13/3 -> busy for 5 cycles; done pulse with quotient=4, remainder=1, div_by_zero=0.
REQ-029 Sweep all 256 operand pairs: 15/1 -> 15,0; 2/9 -> 0,2; 15/15 -> 1,0; divisor 0 cases per REQ-030; all others checked against the REQ-023 identity.
REQ-030 start with 7/0 -> done in the cycle after the accepting edge; quotient=15, remainder=7, div_by_zero=1; a following 6/3 -> 2,0 with div_by_zero cleared.
REQ-031 Hold start=1 continuously across 13/3 with operands changed mid-RUN -> result still 4,1; the DONE-cycle start is ignored and the next operation starts from IDLE.
REQ-032 Drop rst_n for a fraction of a cycle at RUN edge 3 -> all outputs 0 at once, no done pulse, and a new 9/2 after release -> 4,1.
REQ-033 Check the done pulse width is exactly 1 cycle and that quotient/remainder stay stable during RUN (assertions run on all scenarios).
